// File: rtl/ahb_arbiter_slave_1_if.sv
// Bus bundle between the slave_1 arbiter and the interconnect fabric.
// Handshake: an address phase is accepted on a rising HCLK edge where
// hready=1. hready=0 stalls every grant-related register. The arbiter never
// back-pressures, so hready is the only flow-control term.
interface ahb_arbiter_slave_1_if #(
  parameter int CHANNEL_NUM = 3,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
);
  logic [CHANNEL_NUM-1:0] hreq;
  logic                   hmastlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [CHANNEL_NUM-1:0] sel_addr;
  logic [CHANNEL_NUM-1:0] sel_data;
  logic [IDX_W-1:0]       owner_idx;
  logic                   owner_valid;
  logic [1:0]             dbg_state;
  logic [3:0]             dbg_beats_left;

  modport slave (
    input  hreq, hmastlock, htrans, hburst, hready,
    output sel_addr, sel_data, owner_idx, owner_valid, dbg_state, dbg_beats_left
  );

  modport master (
    output hreq, hmastlock, htrans, hburst, hready,
    input  sel_addr, sel_data, owner_idx, owner_valid, dbg_state, dbg_beats_left
  );
endinterface

// File: rtl/ahb_arbiter_slave_1.sv
// Round-robin, burst- and lock-aware owner arbiter for AHB slave_1.
// Produces the address-phase select and a data-phase select that trails it
// by one accepted transfer.
module ahb_arbiter_slave_1 #(
  parameter int CHANNEL_NUM = 3,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_arbiter_slave_1_if.slave bus
);
  localparam logic [1:0] ST_NO_OWNER = 2'd0;
  localparam logic [1:0] ST_OWNED    = 2'd1;
  localparam logic [1:0] ST_BURST    = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d, sel_data_q;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]             state_q, state_d;
  logic [3:0]             beats_left_q, beats_left_d;

  logic                   open_burst;   // NONSEQ of a fixed-length burst
  logic                   arb;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [3:0]             burst_len_m1;
  logic [IDX_W-1:0]       owner_idx;

  // Classify the owner's current transfer and the length of a fixed burst.
  always_comb begin
    open_burst = (bus.htrans == TR_NONSEQ) &&
                 (bus.hburst != HB_SINGLE) && (bus.hburst != HB_INCR);
    case (bus.hburst)
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      default:    burst_len_m1 = 4'd15;
    endcase
  end

  // Arbitration point: only on accepted edges, never inside a locked sequence.
  always_comb begin
    arb = 1'b0;
    if (bus.hready) begin
      case (state_q)
        ST_NO_OWNER: arb = 1'b1;
        ST_OWNED: arb = !bus.hmastlock &&
                        ((bus.htrans == TR_IDLE) ||
                         ((bus.htrans == TR_NONSEQ) && !open_burst) ||
                         ((bus.htrans == TR_SEQ) && (bus.hburst == HB_INCR)));
        ST_BURST: arb = !bus.hmastlock &&
                        ((bus.htrans == TR_IDLE) ||
                         ((bus.htrans == TR_SEQ) && (beats_left_q == 4'd1)));
        default: arb = 1'b1;
      endcase
    end
  end

  // Round-robin search starting just after the last winner; the last winner
  // is visited last so it keeps the bus only when nobody else asks.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      cand     = (int'(rr_ptr_q) + k) % CHANNEL_NUM;
      cand_idx = IDX_W'(cand);
      if (!found && bus.hreq[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Next-state: ownership changes at ARB, burst tracking otherwise.
  // A fixed-length NONSEQ in OWNED is never an ARB, so burst entry always
  // keeps the current owner.
  always_comb begin
    sel_addr_d   = sel_addr_q;
    rr_ptr_d     = rr_ptr_q;
    state_d      = state_q;
    beats_left_d = beats_left_q;
    if (arb) begin
      beats_left_d = '0;
      if (found) begin
        sel_addr_d = {{(CHANNEL_NUM-1){1'b0}}, 1'b1} << winner;
        rr_ptr_d   = winner;
        state_d    = ST_OWNED;
      end else begin
        sel_addr_d = '0;
        state_d    = ST_NO_OWNER;
      end
    end else if (bus.hready) begin
      case (state_q)
        ST_OWNED: begin
          if (open_burst) begin
            state_d      = ST_BURST;
            beats_left_d = burst_len_m1;
          end
        end
        ST_BURST: begin
          // Locked bursts finish here without an ARB and fall back to OWNED.
          if (bus.htrans == TR_SEQ) begin
            if (beats_left_q <= 4'd1) begin
              beats_left_d = '0;
              state_d      = ST_OWNED;
            end else begin
              beats_left_d = beats_left_q - 4'd1;
            end
          end else if (bus.htrans == TR_IDLE) begin
            beats_left_d = '0;
            state_d      = ST_OWNED;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; data-phase select follows address select on accepted edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_addr_q   <= '0;
      sel_data_q   <= '0;
      rr_ptr_q     <= IDX_W'(CHANNEL_NUM - 1);
      state_q      <= ST_NO_OWNER;
      beats_left_q <= '0;
    end else begin
      sel_addr_q   <= sel_addr_d;
      rr_ptr_q     <= rr_ptr_d;
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      if (bus.hready) sel_data_q <= sel_addr_q;
    end
  end

  // Binary owner index decoded from the one-hot address select.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_addr_q[i]) owner_idx = IDX_W'(i);
    end
  end

  assign bus.sel_addr       = sel_addr_q;
  assign bus.sel_data       = sel_data_q;
  assign bus.owner_idx      = owner_idx;
  assign bus.owner_valid    = |sel_addr_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_beats_left = beats_left_q;
endmodule

// File: tb/tb_ahb_arbiter_slave_1.sv
// Directed bench for the slave_1 arbiter: each step drives one cycle of
// inputs and queues the register values expected after the following edge.
module tb_ahb_arbiter_slave_1;
  localparam int N = 3;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;
  localparam logic [1:0] S_NO = 2'd0, S_OW = 2'd1, S_BU = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_arbiter_slave_1_if #(.CHANNEL_NUM(N)) bus();

  ahb_arbiter_slave_1 #(.CHANNEL_NUM(N)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.slave)
  );

  // {sel_addr, sel_data, state, beats_left}
  logic [11:0] exp_q[$];
  logic [11:0] e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [2:0] a);
    case (a)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Monitor: pops one expectation per clock and compares against the DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sel_addr",    16'(bus.sel_addr),       16'(e[11:9]));
      check("sel_data",    16'(bus.sel_data),       16'(e[8:6]));
      check("state",       16'(bus.dbg_state),      16'(e[5:4]));
      check("beats_left",  16'(bus.dbg_beats_left), 16'(e[3:0]));
      check("owner_idx",   16'(bus.owner_idx),      16'(idx_of(e[11:9])));
      check("owner_valid", 16'(bus.owner_valid),    16'(e[11:9] != 3'b000));
      check("onehot_addr", 16'($onehot0(bus.sel_addr)), 16'd1);
      check("onehot_data", 16'($onehot0(bus.sel_data)), 16'd1);
    end
  end

  task automatic step(input logic [2:0] hreq, input logic lock, input logic [1:0] tr,
                      input logic [2:0] hb, input logic rdy,
                      input logic [2:0] ea, input logic [2:0] ed,
                      input logic [1:0] es, input logic [3:0] eb);
    @(negedge clk);
    #1;
    bus.hreq      = hreq;
    bus.hmastlock = lock;
    bus.htrans    = tr;
    bus.hburst    = hb;
    bus.hready    = rdy;
    exp_q.push_back({ea, ed, es, eb});
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    bus.hreq      = '0;
    bus.hmastlock = 1'b0;
    bus.htrans    = IDLE;
    bus.hburst    = 3'd0;
    bus.hready    = 1'b1;
    #2;
    check("rst_sel_addr",    16'(bus.sel_addr),       16'd0);
    check("rst_sel_data",    16'(bus.sel_data),       16'd0);
    check("rst_owner_valid", 16'(bus.owner_valid),    16'd0);
    check("rst_owner_idx",   16'(bus.owner_idx),      16'd0);
    check("rst_state",       16'(bus.dbg_state),      16'(S_NO));
    check("rst_beats",       16'(bus.dbg_beats_left), 16'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.hreq = '0; bus.hmastlock = 1'b0; bus.htrans = IDLE; bus.hburst = 3'd0; bus.hready = 1'b1;
    do_reset();

    // First grant, stall in NO_OWNER, owner release to NO_OWNER
    step(3'b100, 0, IDLE, 3'd0, 0, 3'b000, 3'b000, S_NO, 4'd0);
    step(3'b010, 0, IDLE, 3'd0, 1, 3'b010, 3'b000, S_OW, 4'd0);
    step(3'b010, 0, IDLE, 3'd0, 1, 3'b010, 3'b010, S_OW, 4'd0);
    step(3'b000, 0, IDLE, 3'd0, 1, 3'b000, 3'b010, S_NO, 4'd0);
    step(3'b000, 0, IDLE, 3'd0, 1, 3'b000, 3'b000, S_NO, 4'd0);
    drain();
    do_reset();

    // Round-robin rotation with SINGLE transfers
    step(3'b111, 0, NS, 3'd0, 1, 3'b001, 3'b000, S_OW, 4'd0);
    step(3'b111, 0, NS, 3'd0, 1, 3'b010, 3'b001, S_OW, 4'd0);
    step(3'b111, 0, NS, 3'd0, 1, 3'b100, 3'b010, S_OW, 4'd0);
    step(3'b111, 0, NS, 3'd0, 1, 3'b001, 3'b100, S_OW, 4'd0);

    // INCR4 by owner 0 with master 2 waiting
    step(3'b101, 0, NS, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd3);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd2);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd1);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b100, 3'b001, S_OW, 4'd0);

    // INCR4 with two wait states and a BUSY
    step(3'b001, 0, IDLE, 3'd0, 1, 3'b001, 3'b100, S_OW, 4'd0);
    step(3'b101, 0, NS, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd3);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd2);
    step(3'b101, 0, SQ, 3'd3, 0, 3'b001, 3'b001, S_BU, 4'd2);
    step(3'b101, 0, SQ, 3'd3, 0, 3'b001, 3'b001, S_BU, 4'd2);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd1);
    step(3'b101, 0, BUSY, 3'd3, 1, 3'b001, 3'b001, S_BU, 4'd1);
    step(3'b101, 0, SQ, 3'd3, 1, 3'b100, 3'b001, S_OW, 4'd0);

    // Locked SINGLE sequence by owner 1
    step(3'b010, 0, IDLE, 3'd0, 1, 3'b010, 3'b100, S_OW, 4'd0);
    step(3'b111, 1, NS, 3'd0, 1, 3'b010, 3'b010, S_OW, 4'd0);
    step(3'b111, 1, NS, 3'd0, 1, 3'b010, 3'b010, S_OW, 4'd0);
    step(3'b111, 1, NS, 3'd0, 1, 3'b010, 3'b010, S_OW, 4'd0);
    step(3'b111, 0, NS, 3'd0, 1, 3'b100, 3'b010, S_OW, 4'd0);

    // INCR8 interrupted by reset at beats_left=5
    step(3'b100, 0, NS, 3'd5, 1, 3'b100, 3'b100, S_BU, 4'd7);
    step(3'b100, 0, SQ, 3'd5, 1, 3'b100, 3'b100, S_BU, 4'd6);
    step(3'b100, 0, SQ, 3'd5, 1, 3'b100, 3'b100, S_BU, 4'd5);
    drain();
    do_reset();
    step(3'b001, 0, IDLE, 3'd0, 1, 3'b001, 3'b000, S_OW, 4'd0);

    // WRAP4 early termination, then owner drop outside an ARB
    step(3'b011, 0, NS, 3'd2, 1, 3'b001, 3'b001, S_BU, 4'd3);
    step(3'b011, 0, SQ, 3'd2, 1, 3'b001, 3'b001, S_BU, 4'd2);
    step(3'b011, 0, IDLE, 3'd2, 1, 3'b010, 3'b001, S_OW, 4'd0);
    step(3'b001, 0, BUSY, 3'd1, 1, 3'b010, 3'b010, S_OW, 4'd0);
    step(3'b001, 0, IDLE, 3'd0, 1, 3'b001, 3'b010, S_OW, 4'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter_slave_1.md
Name: ahb_arbiter_slave_1

Overview:
- Per-slave-port arbiter for the AHB interconnect. Decides which master owns slave_1.
- Generates the one-hot address-phase select for the master-to-slave payload mux, plus a one-cycle-delayed data-phase select for write-data/response routing.
- Round-robin, burst-aware and lock-aware. Grants change only on HREADY-qualified boundaries.

Parameters:
- CHANNEL_NUM, 3: number of masters that can address slave_1.
- IDX_W, $clog2(CHANNEL_NUM) (min 1): width of the owner index.

Ports:
- HCLK  input  1  single clock; all state is on its rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- hreq  input  CHANNEL_NUM  per-master request; decoder hit on slave_1 while the master issues NONSEQ/SEQ/BUSY.
- hmastlock  input  1  HMASTLOCK of the current owner (muxed).
- htrans  input  2  HTRANS of the current owner (muxed): IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hburst  input  3  HBURST of the current owner (muxed).
- hready  input  1  slave HREADYOUT.
- sel_addr  output  CHANNEL_NUM  one-hot or zero; address-phase mux select.
- sel_data  output  CHANNEL_NUM  one-hot or zero; data-phase select.
- owner_idx  output  IDX_W  binary index of sel_addr; 0 when no owner.
- owner_valid  output  1  asserted when sel_addr != 0.

Behaviour:
- Reset (async assert, sync release): sel_addr=0, sel_data=0, owner_idx=0, owner_valid=0, rr_ptr=CHANNEL_NUM-1, beats_left=0, state=NO_OWNER.
- State machine states: NO_OWNER, OWNED, BURST.
- Arbitration point (ARB): an edge at which hready=1 and any of:
  - state=NO_OWNER; or
  - state=OWNED, hmastlock=0, and htrans is IDLE, NONSEQ with hburst SINGLE(0) or INCR(1), or SEQ with hburst INCR; or
  - state=BURST, hmastlock=0, htrans=SEQ, beats_left=1 (last beat accepted).
- ARB winner: first set bit of hreq searching rr_ptr+1, rr_ptr+2, ... (mod CHANNEL_NUM).
  - The current owner keeps the bus if no other master requests.
- ARB result registered (1-cycle latency):
  - Winner found: sel_addr=onehot(winner), rr_ptr=winner, state=OWNED.
  - No hreq: sel_addr=0, state=NO_OWNER, rr_ptr unchanged.
- Burst entry, evaluated on the same edge only when the ARB result keeps the same owner (otherwise ignored):
  - Condition: hready=1, htrans=NONSEQ, hburst in {WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7}.
  - Effect: beats_left = len-1 (3/7/15), state=BURST.
  - When a fixed-length NONSEQ is accepted in OWNED, the arbitration point is suppressed; the ownership test above applies only to SINGLE/INCR.
- In BURST:
  - hready=1 and htrans=SEQ: beats_left decrements.
  - BUSY or hready=0: hold.
  - IDLE (early termination): forces ARB.
- hmastlock=1 blocks every ARB except NO_OWNER. The owner is held across locked sequences until the first hready=1 cycle with hmastlock=0.
- hready=0: sel_addr, state, beats_left and rr_ptr all frozen.
- sel_data: on each edge with hready=1, sel_data <= sel_addr; otherwise held.
- Owner dropping hreq outside an ARB is ignored until the next ARB.
- owner_idx and owner_valid are combinational from sel_addr.
- Invariants: $onehot0(sel_addr) and $onehot0(sel_data) always.
- Reset mid-burst: everything returns to reset values immediately; no partial state survives.

Test Plan:
- Reset, then hreq=3'b010 with hready=1 → next cycle sel_addr=010, owner_idx=1; one cycle later sel_data=010.
- hreq=3'b111, every owner issuing SINGLE NONSEQ, hready=1 → sel_addr rotates 001→010→100→001 on successive ARBs (rr_ptr reset to 2).
- Owner 0 starts INCR4 (NONSEQ then 3×SEQ) while hreq[2]=1 → sel_addr stays 001 through beats_left 3→0; switches to 100 on the edge after the last SEQ is accepted.
- Same INCR4 with hready=0 held for 2 cycles on beat 2, plus one BUSY → grant held; beats_left unchanged during stalls; handoff still after the 4th beat.
- Owner 1 with hmastlock=1, SINGLE transfers, hreq=111 → sel_addr stays 010 for every transfer; rotates to 100 on the first hready=1 edge with hmastlock=0.
- HRESETn low mid-INCR8 (beats_left=5) → sel_addr=0, sel_data=0, owner_valid=0 asynchronously; after release with hreq=001 → sel_addr=001 after 1 cycle.
